// File: rtl/assign_trail_stack.sv
// Assignment trail stack for a SAT-solver datapath. Holds {dec, val, var}
// entries, supports push/pop/clear and a multi-cycle backtrack that unwinds
// entries down to and including the most recent decision.
module assign_trail_stack #(
    parameter int NUM_VARIABLE = 128,
    parameter int VAR_W        = 9,
    parameter int DEPTH        = 128,
    parameter int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [VAR_W-1:0] push_var,
    input  logic             push_val,
    input  logic             push_dec,
    output logic             rd_valid,
    output logic [VAR_W-1:0] rd_var,
    output logic             rd_val,
    output logic             rd_dec,
    output logic             bt_done,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             err_ovf,
    output logic             err_udf
);

    // State table
    // S_IDLE | accepting commands
    // S_BT   | unwinding one entry per cycle until a decision entry or empty

    typedef enum logic {S_IDLE, S_BT} state_t;

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          EW       = VAR_W + 2;
    localparam logic [1:0]  OP_PUSH  = 2'b00;
    localparam logic [1:0]  OP_POP   = 2'b01;
    localparam logic [1:0]  OP_BT    = 2'b10;
    localparam logic [1:0]  OP_CLEAR = 2'b11;

    // A variable index must be able to represent every solver variable.
    if (VAR_W < $clog2(NUM_VARIABLE + 1)) begin : g_bad_var_w
        $error("VAR_W too narrow for NUM_VARIABLE");
    end

    logic [EW-1:0]    mem [DEPTH];
    state_t           state, state_nxt;
    logic             accept;
    logic             do_push, do_pop, bt_last, bt_empty;
    logic [AW-1:0]    wr_idx, top_idx;
    logic [EW-1:0]    top_entry;
    logic             top_dec;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));

    // Write slot is only used when not full, so the truncation never aliases.
    assign wr_idx    = AW'(count);
    assign top_idx   = AW'(count - CNT_W'(1));
    assign top_entry = mem[top_idx];
    assign top_dec   = top_entry[EW-1];

    assign do_push   = accept && (cmd_op == OP_PUSH) && !full;
    // Count is always nonzero while in S_BT, so the top entry is valid there.
    assign do_pop    = (accept && (cmd_op == OP_POP) && !empty) || (state == S_BT);
    assign bt_last   = (state == S_BT) && (top_dec || (count == CNT_W'(1)));
    assign bt_empty  = accept && (cmd_op == OP_BT) && empty;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && (cmd_op == OP_BT) && !empty) state_nxt = S_BT;
            S_BT:   if (bt_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, read-out register, strobes and sticky error flags
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count    <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_var   <= '0;
            rd_val   <= 1'b0;
            rd_dec   <= 1'b0;
            bt_done  <= 1'b0;
            err_ovf  <= 1'b0;
            err_udf  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            bt_done  <= 1'b0;
            if (do_push) begin
                count <= count + CNT_W'(1);
                if (push_dec) level <= level + CNT_W'(1);
            end else if (do_pop) begin
                rd_valid <= 1'b1;
                rd_var   <= top_entry[VAR_W-1:0];
                rd_val   <= top_entry[VAR_W];
                rd_dec   <= top_dec;
                count    <= count - CNT_W'(1);
                level    <= level - CNT_W'(top_dec);
            end else if (accept && (cmd_op == OP_CLEAR)) begin
                count <= '0;
                level <= '0;
            end
            if (accept && (cmd_op == OP_PUSH) && full)  err_ovf <= 1'b1;
            if (accept && (cmd_op == OP_POP) && empty)  err_udf <= 1'b1;
            if (bt_last || bt_empty)                    bt_done <= 1'b1;
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_idx] <= {push_dec, push_val, push_var};
    end

endmodule

// File: tb/tb_assign_trail_stack.sv
// Directed bench for assign_trail_stack: a vector table for the main
// push/pop/backtrack flows plus hand sequences for overflow and mid-backtrack reset.
module tb_assign_trail_stack;

    localparam int VW  = 9;
    localparam int CWA = $clog2(128 + 1);
    localparam int CWB = $clog2(4 + 1);

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic valid_a = 1'b0, valid_b = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [VW-1:0] push_var = '0;
    logic push_val = 1'b0, push_dec = 1'b0;

    logic a_ready, a_rv, a_rval, a_rdec, a_bt, a_empty, a_full, a_ovf, a_udf;
    logic [VW-1:0] a_rvar;
    logic [CWA-1:0] a_cnt, a_lvl;

    logic b_ready, b_rv, b_rval, b_rdec, b_bt, b_empty, b_full, b_ovf, b_udf;
    logic [VW-1:0] b_rvar;
    logic [CWB-1:0] b_cnt, b_lvl;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign_trail_stack u_dut (
        .clock(clock), .reset(reset), .cmd_valid(valid_a), .cmd_ready(a_ready),
        .cmd_op(cmd_op), .push_var(push_var), .push_val(push_val), .push_dec(push_dec),
        .rd_valid(a_rv), .rd_var(a_rvar), .rd_val(a_rval), .rd_dec(a_rdec),
        .bt_done(a_bt), .count(a_cnt), .level(a_lvl), .empty(a_empty), .full(a_full),
        .err_ovf(a_ovf), .err_udf(a_udf)
    );

    assign_trail_stack #(.DEPTH(4)) u_small (
        .clock(clock), .reset(reset), .cmd_valid(valid_b), .cmd_ready(b_ready),
        .cmd_op(cmd_op), .push_var(push_var), .push_val(push_val), .push_dec(push_dec),
        .rd_valid(b_rv), .rd_var(b_rvar), .rd_val(b_rval), .rd_dec(b_rdec),
        .bt_done(b_bt), .count(b_cnt), .level(b_lvl), .empty(b_empty), .full(b_full),
        .err_ovf(b_ovf), .err_udf(b_udf)
    );

    typedef struct {
        logic          valid;
        logic [1:0]    op;
        logic [VW-1:0] vr;
        logic          vl;
        logic          dc;
        logic          rv;
        logic [VW-1:0] rvar;
        logic          rval;
        logic          rdec;
        logic          bt;
        int            cnt;
        int            lvl;
        logic          rdy;
        logic          emp;
        logic          udf;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic v, input logic [1:0] op, input int vr,
                                input logic vl, input logic dc, input logic rv,
                                input int rvar, input logic rval, input logic rdec,
                                input logic bt, input int cnt, input int lvl,
                                input logic rdy, input logic emp, input logic udf);
        vec_t r;
        r.valid = v;   r.op = op;     r.vr = VW'(vr); r.vl = vl;     r.dc = dc;
        r.rv = rv;     r.rvar = VW'(rvar); r.rval = rval; r.rdec = rdec;
        r.bt = bt;     r.cnt = cnt;   r.lvl = lvl;    r.rdy = rdy;   r.emp = emp;
        r.udf = udf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic va, input logic vb, input logic [1:0] op,
                        input int vr, input logic vl, input logic dc);
        @(negedge clock);
        valid_a  = va;
        valid_b  = vb;
        cmd_op   = op;
        push_var = VW'(vr);
        push_val = vl;
        push_dec = dc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // op codes: 0 PUSH, 1 POP, 2 BACKTRACK, 3 CLEAR
        //              v op var vl dc | rv rvar rval rdec bt cnt lvl rdy emp udf
        vecs[0]  = mk(1, 0,  5, 1, 1,   0,  0, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[1]  = mk(1, 0,  7, 0, 0,   0,  0, 0, 0, 0, 2, 1, 1, 0, 0);
        vecs[2]  = mk(1, 0,  9, 1, 0,   0,  0, 0, 0, 0, 3, 1, 1, 0, 0);
        vecs[3]  = mk(1, 1,  0, 0, 0,   1,  9, 1, 0, 0, 2, 1, 1, 0, 0);
        vecs[4]  = mk(1, 1,  0, 0, 0,   1,  7, 0, 0, 0, 1, 1, 1, 0, 0);
        vecs[5]  = mk(1, 1,  0, 0, 0,   1,  5, 1, 1, 0, 0, 0, 1, 1, 0);
        vecs[6]  = mk(1, 0,  3, 1, 1,   0,  5, 1, 1, 0, 1, 1, 1, 0, 0);
        vecs[7]  = mk(1, 0,  4, 0, 0,   0,  5, 1, 1, 0, 2, 1, 1, 0, 0);
        vecs[8]  = mk(1, 0,  6, 1, 1,   0,  5, 1, 1, 0, 3, 2, 1, 0, 0);
        vecs[9]  = mk(1, 0,  8, 0, 0,   0,  5, 1, 1, 0, 4, 2, 1, 0, 0);
        vecs[10] = mk(1, 0,  2, 1, 0,   0,  5, 1, 1, 0, 5, 2, 1, 0, 0);
        vecs[11] = mk(1, 2,  0, 0, 0,   0,  5, 1, 1, 0, 5, 2, 0, 0, 0);
        vecs[12] = mk(0, 0,  0, 0, 0,   1,  2, 1, 0, 0, 4, 2, 0, 0, 0);
        vecs[13] = mk(1, 0,  1, 1, 1,   1,  8, 0, 0, 0, 3, 2, 0, 0, 0);
        vecs[14] = mk(0, 0,  0, 0, 0,   1,  6, 1, 1, 1, 2, 1, 1, 0, 0);
        vecs[15] = mk(0, 0,  0, 0, 0,   0,  6, 1, 1, 0, 2, 1, 1, 0, 0);
        vecs[16] = mk(1, 3,  0, 0, 0,   0,  6, 1, 1, 0, 0, 0, 1, 1, 0);
        vecs[17] = mk(1, 0, 10, 0, 0,   0,  6, 1, 1, 0, 1, 0, 1, 0, 0);
        vecs[18] = mk(1, 0, 11, 1, 0,   0,  6, 1, 1, 0, 2, 0, 1, 0, 0);
        vecs[19] = mk(1, 0, 12, 0, 0,   0,  6, 1, 1, 0, 3, 0, 1, 0, 0);
        vecs[20] = mk(1, 2,  0, 0, 0,   0,  6, 1, 1, 0, 3, 0, 0, 0, 0);
        vecs[21] = mk(0, 0,  0, 0, 0,   1, 12, 0, 0, 0, 2, 0, 0, 0, 0);
        vecs[22] = mk(0, 0,  0, 0, 0,   1, 11, 1, 0, 0, 1, 0, 0, 0, 0);
        vecs[23] = mk(0, 0,  0, 0, 0,   1, 10, 0, 0, 1, 0, 0, 1, 1, 0);
        vecs[24] = mk(1, 1,  0, 0, 0,   0, 10, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[25] = mk(1, 2,  0, 0, 0,   0, 10, 0, 0, 1, 0, 0, 1, 1, 1);
        vecs[26] = mk(0, 0,  0, 0, 0,   0, 10, 0, 0, 0, 0, 0, 1, 1, 1);
        vecs[27] = mk(1, 3,  0, 0, 0,   0, 10, 0, 0, 0, 0, 0, 1, 1, 1);

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst count",   32'(a_cnt), 0);
        chk("rst level",   32'(a_lvl), 0);
        chk("rst empty",   32'(a_empty), 1);
        chk("rst full",    32'(a_full), 0);
        chk("rst ready",   32'(a_ready), 1);
        chk("rst rd_valid",32'(a_rv), 0);
        chk("rst bt_done", 32'(a_bt), 0);
        chk("rst rd_var",  32'(a_rvar), 0);
        chk("rst errs",    32'({a_ovf, a_udf}), 0);
        @(negedge clock);
        reset = 1'b1;

        // Table-driven flows on the deep stack
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].valid, 1'b0, vecs[i].op, int'(vecs[i].vr), vecs[i].vl, vecs[i].dc);
            chk($sformatf("v%0d rd_valid", i), 32'(a_rv),    32'(vecs[i].rv));
            chk($sformatf("v%0d rd_var", i),   32'(a_rvar),  32'(vecs[i].rvar));
            chk($sformatf("v%0d rd_val", i),   32'(a_rval),  32'(vecs[i].rval));
            chk($sformatf("v%0d rd_dec", i),   32'(a_rdec),  32'(vecs[i].rdec));
            chk($sformatf("v%0d bt_done", i),  32'(a_bt),    32'(vecs[i].bt));
            chk($sformatf("v%0d count", i),    32'(a_cnt),   32'(vecs[i].cnt));
            chk($sformatf("v%0d level", i),    32'(a_lvl),   32'(vecs[i].lvl));
            chk($sformatf("v%0d ready", i),    32'(a_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d empty", i),    32'(a_empty), 32'(vecs[i].emp));
            chk($sformatf("v%0d err_udf", i),  32'(a_udf),   32'(vecs[i].udf));
            chk($sformatf("v%0d err_ovf", i),  32'(a_ovf),   0);
        end

        // Overflow on the 4-deep stack
        step(0, 1, 2'b00, 21, 1, 1);
        step(0, 1, 2'b00, 22, 0, 0);
        step(0, 1, 2'b00, 23, 1, 0);
        chk("ovf full after 3", 32'(b_full), 0);
        step(0, 1, 2'b00, 24, 0, 1);
        chk("ovf full after 4", 32'(b_full), 1);
        chk("ovf count after 4", 32'(b_cnt), 4);
        chk("ovf level after 4", 32'(b_lvl), 2);
        chk("ovf flag after 4", 32'(b_ovf), 0);
        step(0, 1, 2'b00, 25, 1, 1);
        chk("ovf flag after 5", 32'(b_ovf), 1);
        chk("ovf count after 5", 32'(b_cnt), 4);
        chk("ovf level after 5", 32'(b_lvl), 2);
        step(0, 1, 2'b01, 0, 0, 0);
        chk("ovf pop rd_valid", 32'(b_rv), 1);
        chk("ovf pop rd_var", 32'(b_rvar), 24);
        chk("ovf pop rd_val", 32'(b_rval), 0);
        chk("ovf pop rd_dec", 32'(b_rdec), 1);
        chk("ovf pop count", 32'(b_cnt), 3);
        chk("ovf pop level", 32'(b_lvl), 1);
        chk("ovf pop full", 32'(b_full), 0);

        // Reset in the middle of a backtrack
        step(1, 0, 2'b00, 13, 0, 0);
        step(1, 0, 2'b00, 14, 1, 0);
        step(1, 0, 2'b00, 15, 0, 0);
        step(1, 0, 2'b10, 0, 0, 0);
        step(0, 0, 2'b00, 0, 0, 0);
        chk("mid-bt ready", 32'(a_ready), 0);
        chk("mid-bt rd_var", 32'(a_rvar), 15);
        chk("mid-bt count", 32'(a_cnt), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst count", 32'(a_cnt), 0);
        chk("async rst rd_valid", 32'(a_rv), 0);
        chk("async rst rd_var", 32'(a_rvar), 0);
        chk("async rst ready", 32'(a_ready), 1);
        chk("async rst empty", 32'(a_empty), 1);
        chk("async rst errs", 32'({a_ovf, a_udf}), 0);
        chk("async rst small count", 32'(b_cnt), 0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk($sformatf("post-rst bt_done c%0d", i), 32'(a_bt), 0);
            chk($sformatf("post-rst rd_valid c%0d", i), 32'(a_rv), 0);
        end
        chk("post-rst count", 32'(a_cnt), 0);
        chk("post-rst ready", 32'(a_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
